// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Sequential instruction fetch with a credit-limited buffer toward
//            decode and a redirect flush that discards stale responses.
//            Optional macro FETCH_PREDECODE_EN adds a predecoded format_o.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
`ifdef FETCH_PREDECODE_EN
  output logic [2:0]  format_o,
`endif
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);

  logic [31:0]   r_pc, r_resp_pc;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_outstanding, r_discard;
  logic [31:0]   r_instr_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem    [FIFO_DEPTH];

  logic [CW:0]   w_inflight;
  logic [31:0]   w_target;
  logic          w_fire, w_rsp, w_push, w_pop;
  logic          w_unused;

  assign w_target   = {redirect_pc_i[31:2], 2'b00};
  assign w_unused   = &{1'b0, redirect_pc_i[1:0]};
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};

  // Requests are only issued while a FIFO slot is reserved for the response.
  assign imem_req_o    = rst_ni && !redirect_i && (w_inflight < {1'b0, c_DEPTH});
  assign imem_addr_o   = r_pc;
  assign w_fire        = imem_req_o && imem_gnt_i;
  assign w_rsp         = imem_rvalid_i && (r_outstanding != '0);
  assign w_push        = w_rsp && !redirect_i && (r_discard == '0);
  assign instr_valid_o = (r_count != '0) && !redirect_i;
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign instr_o       = r_instr_mem[r_rd_ptr];
  assign pc_o          = r_pc_mem[r_rd_ptr];

`ifdef FETCH_PREDECODE_EN
  // Encoding mirrors core::formats_t.
  localparam logic [2:0] c_R_FORMAT = 3'd0;
  localparam logic [2:0] c_I_FORMAT = 3'd1;
  localparam logic [2:0] c_S_FORMAT = 3'd2;
  localparam logic [2:0] c_U_FORMAT = 3'd4;

  logic [2:0] r_fmt_mem [FIFO_DEPTH];
  logic [2:0] w_fmt;

  always_comb begin
    w_fmt = c_R_FORMAT;
    case (imem_rdata_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_fmt = c_I_FORMAT;
      7'b0100011:                         w_fmt = c_S_FORMAT;
      7'b0110111, 7'b0010111:             w_fmt = c_U_FORMAT;
      default:                            w_fmt = c_R_FORMAT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fmt_mem[i] <= c_R_FORMAT;
    end else if (w_push) begin
      r_fmt_mem[r_wr_ptr] <= w_fmt;
    end
  end

  assign format_o = r_fmt_mem[r_rd_ptr];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
      end
    end else if (redirect_i) begin
      // Everything still in flight, including a response landing now, is stale.
      r_pc          <= w_target;
      r_resp_pc     <= w_target;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_discard     <= r_outstanding - CW'(w_rsp);
      r_outstanding <= r_outstanding - CW'(w_rsp);
    end else begin
      if (w_fire) r_pc <= r_pc + 32'd4;
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= imem_rdata_i;
        r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
        r_resp_pc             <= r_resp_pc + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_rsp);
      if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_push && (r_count == c_DEPTH)));
      assert (!(imem_rvalid_i && (r_outstanding == '0)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
`ifdef FETCH_PREDECODE_EN
  logic [2:0]  format;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit auto_rsp = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
`ifdef FETCH_PREDECODE_EN
    .format_o      (format),
`endif
    .pc_o          (pc)
  );

  // One clock; in auto mode each grant is answered next cycle with rdata = addr.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    #1;
    f = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rvalid = f;
      imem_rdata  = a;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0; auto_rsp = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", instr); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", pc); end
`ifdef FETCH_PREDECODE_EN
    n_vec++; if (format !== 3'd0) begin n_err++; $display("FAIL reset_format got %0d exp 0", format); end
`endif
    rst_n = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin n_err++; $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; auto_rsp = 1'b1;
    tick();
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid got %0b exp 0", instr_valid); end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (instr_valid !== 1'b1 || pc !== 32'(4 * k) || instr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL stream_%0d got valid=%0b pc=%h instr=%h exp valid=1 pc=%h", k, instr_valid, pc, instr, 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b0; auto_rsp = 1'b1;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_reset_valid got %0b exp 0", instr_valid); end
    for (int k = 0; k < 5; k++) tick();
    n_vec++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h10)
      begin n_err++; $display("FAIL bp_full got req=%0b valid=%0b pc=%h addr=%h exp 0 1 0 10", imem_req, instr_valid, pc, imem_addr); end
    tick(); tick();
    n_vec++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0)
      begin n_err++; $display("FAIL bp_hold got req=%0b pc=%h instr=%h exp 0 0 0", imem_req, pc, instr); end
    instr_ready = 1'b1;
    tick();
    n_vec++; if (pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h10)
      begin n_err++; $display("FAIL bp_resume got pc=%h req=%0b addr=%h exp 4 1 10", pc, imem_req, imem_addr); end
    tick();
    n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL bp_pc8 got %h exp 8", pc); end
    tick();
    n_vec++; if (pc !== 32'hC) begin n_err++; $display("FAIL bp_pc12 got %h exp c", pc); end
    tick();
    n_vec++; if (pc !== 32'h10 || instr !== 32'h10 || instr_valid !== 1'b1)
      begin n_err++; $display("FAIL bp_pc16 got pc=%h instr=%h valid=%0b exp 10 10 1", pc, instr, instr_valid); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h101;
    #1;
    n_vec++; if (imem_req !== 1'b0 || instr_valid !== 1'b0)
      begin n_err++; $display("FAIL rd_suppress got req=%0b valid=%0b exp 0 0", imem_req, instr_valid); end
    tick();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin n_err++; $display("FAIL rd_addr got req=%0b addr=%h exp 1 100", imem_req, imem_addr); end
    tick();
    imem_rdata = 32'hDEAD_0004;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_stale1 got valid=%0b exp 0", instr_valid); end
    tick();
    imem_gnt = 1'b0; imem_rdata = 32'h100;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_stale2 got valid=%0b exp 0", instr_valid); end
    tick();
    imem_rdata = 32'h104;
    n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h100)
      begin n_err++; $display("FAIL rd_first got valid=%0b pc=%h instr=%h exp 1 100 100", instr_valid, pc, instr); end
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h104 || instr !== 32'h104)
      begin n_err++; $display("FAIL rd_second got valid=%0b pc=%h instr=%h exp 1 104 104", instr_valid, pc, instr); end
    tick();
  endtask

  task automatic test_redirect_with_rvalid();
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    imem_rvalid = 1'b1; imem_rdata = 32'h55;
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    n_vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      begin n_err++; $display("FAIL rv_after got valid=%0b req=%0b addr=%h exp 0 1 200", instr_valid, imem_req, imem_addr); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h200;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rv_no_stale got valid=%0b exp 0", instr_valid); end
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h200)
      begin n_err++; $display("FAIL rv_fresh got valid=%0b pc=%h instr=%h exp 1 200 200", instr_valid, pc, instr); end
    tick();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    imem_gnt = 1'b0; instr_ready = 1'b1; auto_rsp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
        begin n_err++; $display("FAIL stall_%0d got req=%0b addr=%h exp 1 0", k, imem_req, imem_addr); end
      tick();
    end
    imem_gnt = 1'b1;
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL stall_grant got addr=%h exp 0", imem_addr); end
    tick();
    imem_gnt = 1'b0;
    n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL stall_inc got addr=%h exp 4", imem_addr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4)
      begin n_err++; $display("FAIL stall_out got valid=%0b pc=%h addr=%h exp 1 0 4", instr_valid, pc, imem_addr); end
  endtask

`ifdef FETCH_PREDECODE_EN
  task automatic test_predecode();
    logic [31:0] words [3];
    logic [2:0]  fmts  [3];
    words[0] = 32'h00A00093; fmts[0] = 3'd1;
    words[1] = 32'h00112223; fmts[1] = 3'd2;
    words[2] = 32'h002081B3; fmts[2] = 3'd0;
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      imem_gnt    = (k < 2);
      imem_rvalid = (k < 3);
      imem_rdata  = (k < 3) ? words[k] : 32'h0;
      if (k >= 1 && k <= 3) begin
        n_vec++; if (instr_valid !== 1'b1 || format !== fmts[k-1])
          begin n_err++; $display("FAIL predecode_%0d got valid=%0b fmt=%0d exp 1 %0d", k - 1, instr_valid, format, fmts[k-1]); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_rvalid();
    test_gnt_stall();
`ifdef FETCH_PREDECODE_EN
    test_predecode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that feeds decode (and, through decode, the immediate generator).
- Generates sequential word PCs and issues requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words with their PCs in a small FIFO and presents them to decode on a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the buffer and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  synchronous active-low reset
- redirect_i  input  1  redirect request; one-cycle pulse
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 0
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch word address
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid; responses return in order
- imem_rdata_i  input  32  response instruction word
- instr_valid_o  output  1  buffer head valid toward decode
- instr_ready_i  input  1  decode accepts head
- instr_o  output  32  head instruction; feeds decode and immediate generator instr_i
- pc_o  output  32  PC of head instruction

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-low on rst_ni.
- Reset values:
  - pc_q and resp_pc_q = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0.
  - Reset asserted mid-operation drops all buffered and in-flight state. Responses arriving after reset is released are not accepted.
- Issue: imem_req_o = !redirect_i && (fifo_count + outstanding < FIFO_DEPTH). imem_addr_o = pc_q.
  - On req && gnt: pc_q += 4 (wraps modulo 2^32) and outstanding++.
  - While req is high without gnt, imem_addr_o is held stable.
- Credit rule: the issue condition guarantees every response has a FIFO slot, so overflow is impossible. Add an assertion for push while full.
- Response, on rvalid:
  - outstanding-- in all cases.
  - If discard > 0: discard-- and the word is dropped.
  - Otherwise: push {resp_pc_q, imem_rdata_i} and resp_pc_q += 4.
- Output:
  - instr_valid_o = !fifo_empty && !redirect_i. instr_o and pc_o are driven from the FIFO head.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - While decode holds instr_ready_i low, the head values are held stable.
- Latency:
  - gnt in cycle N, rvalid earliest N+1, instr_valid_o in N+2.
  - Sustained throughput is 1 instruction per cycle when gnt and rvalid are continuous.
- Redirect, at the clock edge where redirect_i = 1:
  - FIFO cleared (head is not popped that cycle).
  - pc_q and resp_pc_q = {redirect_pc_i[31:2], 2'b00}.
  - discard_next = outstanding_q - (imem_rvalid_i ? 1 : 0), so every remaining in-flight response is stale. An rvalid in the redirect cycle itself is also dropped.
  - No new grant occurs in the redirect cycle because the request is suppressed.
- Back-to-back redirects: the second redirect overrides the first. The discard count is recomputed each time from the total outstanding count.
- Counter widths: outstanding and discard are $clog2(FIFO_DEPTH)+1 bits. Neither may underflow; assert that rvalid never arrives with outstanding == 0.

Optional Feature:
- Macro: FETCH_PREDECODE_EN.
- When defined, the block adds output format_o [2:0] (core::formats_t encoding). The format is predecoded from imem_rdata_i[6:0] at push time and stored in the FIFO beside the instruction; it drives the immediate generator format_i directly.
- Opcode mapping:
  - 0010011, 0000011, 1100111 -> I_FORMAT
  - 0100011 -> S_FORMAT
  - 0110011 -> R_FORMAT
  - 0110111, 0010111 -> U_FORMAT
  - all others -> R_FORMAT (yields zero immediate)
- format_o resets to R_FORMAT and follows the same valid/stability rules as instr_o.
- When not defined, the port and FIFO field are absent and decode derives the format itself.

Test Plan:
- Reset, gnt=1 always, rvalid=1 one cycle after every gnt with rdata=addr, ready=1 -> pc_o/instr_o = 0,4,8,... from cycle 2 onward at 1/cycle.
- Hold ready=0 from reset -> exactly 4 words buffered, imem_req_o low with fifo_count+outstanding=4; raise ready -> in-order pc 0,4,8,12 then fetch resumes at 0x10.
- Two requests granted (0x0, 0x4) with responses still outstanding, then redirect to 0x101 -> both later responses dropped, next imem_addr_o=0x100, first output pc_o=0x100.
- Redirect in the same cycle as an rvalid with outstanding=1 -> that word dropped, discard=0, no stale output.
- gnt withheld 3 cycles -> imem_addr_o stable for all 4 cycles, pc_q increments only on the grant cycle.
- FETCH_PREDECODE_EN: rdata 0x00A00093 (addi x1,x0,10) -> format_o=I_FORMAT; 0x00112223 (sw x1,4(x2)) -> S_FORMAT; 0x002081B3 (add) -> R_FORMAT.
